// File: rtl/timer_ctrl.sv
// rtl/timer_ctrl.sv - one-shot/periodic tick timer sequencer driving an external up/down counter
// Optional macro TIMER_CTRL_EXPCNT_EN adds the saturating expiry counter output exp_cnt.
module timer_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             res,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] period_in,
    input  logic             periodic,
    input  logic             tick,
    input  logic [WIDTH-1:0] cnt_value,
    output logic             cnt_enable,
    output logic             cnt_load,
    output logic             cnt_dir,
    output logic [WIDTH-1:0] cnt_load_val,
    output logic             busy,
`ifdef TIMER_CTRL_EXPCNT_EN
    output logic [7:0]       exp_cnt,
`endif
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_period;
    logic             r_mode;
    logic [WIDTH-1:0] w_period_m1;
    logic             w_accept;
    logic             w_done_next;
    logic             w_err_next;

    assign w_period_m1 = r_period - {{(WIDTH-1){1'b0}}, 1'b1};
    assign cnt_dir     = 1'b1;
    assign busy        = (r_state != IDLE);

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_done_next  = 1'b0;
        w_err_next   = 1'b0;
        cnt_enable   = 1'b0;
        cnt_load     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (period_in != '0) begin
                        w_accept     = 1'b1;
                        w_state_next = LOAD;
                    end else begin
                        w_err_next = 1'b1;
                    end
                end
            end
            LOAD: begin
                cnt_enable   = 1'b1;
                cnt_load     = 1'b1;
                w_state_next = RUN;
            end
            RUN: begin
                if (stop) begin
                    w_state_next = IDLE;
                end else if (cnt_value > w_period_m1) begin
                    w_err_next   = 1'b1;
                    w_state_next = IDLE;
                end else if (tick && (cnt_value == '0)) begin
                    // Reload on the expiry tick itself so a periodic timer never loses a tick.
                    w_done_next = 1'b1;
                    if (r_mode) begin
                        cnt_enable = 1'b1;
                        cnt_load   = 1'b1;
                    end else begin
                        w_state_next = IDLE;
                    end
                end else if (tick) begin
                    cnt_enable = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
        cnt_load_val = cnt_load ? w_period_m1 : '0;
    end

    always_ff @(posedge clk) begin
        if (res) begin
            r_state  <= IDLE;
            r_period <= '0;
            r_mode   <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            done    <= w_done_next;
            err     <= w_err_next;
            if (w_accept) begin
                r_period <= period_in;
                r_mode   <= periodic;
            end
        end
    end

`ifdef TIMER_CTRL_EXPCNT_EN
    always_ff @(posedge clk) begin
        if (res || w_accept) begin
            exp_cnt <= 8'h00;
        end else if (w_done_next && (exp_cnt != 8'hFF)) begin
            exp_cnt <= exp_cnt + 8'h01;
        end
    end
`endif

endmodule

// File: tb/tb_timer_ctrl.sv
// tb/tb_timer_ctrl.sv - directed self-checking bench for timer_ctrl with a behavioural down counter
module tb_timer_ctrl;

    logic       clk = 1'b0;
    logic       res;
    logic       start;
    logic       stop;
    logic [7:0] period_in;
    logic       periodic;
    logic       tick;
    logic [7:0] cnt_value;
    logic       cnt_enable;
    logic       cnt_load;
    logic       cnt_dir;
    logic [7:0] cnt_load_val;
    logic       busy;
    logic       done;
    logic       err;
`ifdef TIMER_CTRL_EXPCNT_EN
    logic [7:0] exp_cnt;
`endif

    logic [7:0] r_cnt;
    logic       force_en;
    logic [7:0] force_val;
    int         n_tests = 0;
    int         n_fail  = 0;

    timer_ctrl #(.WIDTH(8)) dut (
        .clk          (clk),
        .res          (res),
        .start        (start),
        .stop         (stop),
        .period_in    (period_in),
        .periodic     (periodic),
        .tick         (tick),
        .cnt_value    (cnt_value),
        .cnt_enable   (cnt_enable),
        .cnt_load     (cnt_load),
        .cnt_dir      (cnt_dir),
        .cnt_load_val (cnt_load_val),
        .busy         (busy),
`ifdef TIMER_CTRL_EXPCNT_EN
        .exp_cnt      (exp_cnt),
`endif
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    // Behavioural model of the controlled up/down counter.
    always @(posedge clk) begin
        if (cnt_enable) begin
            if (cnt_load)     r_cnt <= cnt_load_val;
            else if (cnt_dir) r_cnt <= r_cnt - 8'd1;
            else              r_cnt <= r_cnt + 8'd1;
        end
    end

    assign cnt_value = force_en ? force_val : r_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    int done_cyc[$];
    int err_seen;
    int busy_low;

    initial begin
        res = 1'b1; start = 1'b0; stop = 1'b0; period_in = 8'd0; periodic = 1'b0;
        tick = 1'b0; force_en = 1'b0; force_val = 8'd0; r_cnt = 8'd0;
        nxt(); nxt();
        settle();
        chk("rst_busy", busy, 0);
        chk("rst_en", cnt_enable, 0);
        chk("rst_load", cnt_load, 0);
        chk("rst_lval", cnt_load_val, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_dir", cnt_dir, 1);
        res = 1'b0;

        // one-shot period 5, tick every cycle
        nxt(); start = 1'b1; period_in = 8'd5; periodic = 1'b0; tick = 1'b1;
        nxt(); start = 1'b0; settle();
        chk("t1_load", cnt_load, 1);
        chk("t1_en", cnt_enable, 1);
        chk("t1_lval", cnt_load_val, 4);
        chk("t1_busy", busy, 1);
        nxt(); settle();
        chk("t1_first", cnt_value, 4);
        chk("t1_dec", {cnt_enable, cnt_load}, 2'b10);
        nxt(); nxt(); nxt(); nxt(); settle();
        chk("t1_zero", cnt_value, 0);
        chk("t1_nocmd", cnt_enable, 0);
        chk("t1_done_early", done, 0);
        nxt(); settle();
        chk("t1_done", done, 1);
        chk("t1_idle", busy, 0);
        nxt(); settle();
        chk("t1_done_pulse", done, 0);
        chk("t1_hold0", cnt_value, 0);

        // periodic period 3, tick on even cycles; busy start with period 0 ignored
        nxt(); start = 1'b1; period_in = 8'd3; periodic = 1'b1; tick = 1'b0;
        err_seen = 0; busy_low = 0;
        for (int c = 1; c <= 20; c++) begin
            nxt();
            start = (c == 9);
            period_in = (c == 9) ? 8'd0 : 8'd3;
            tick = (c % 2 == 0);
            settle();
            if (done) done_cyc.push_back(c);
            if (err) err_seen++;
            if (!busy) busy_low++;
        end
        chk("t2_ndone", done_cyc.size(), 3);
        chk("t2_d0", (done_cyc.size() > 0) ? done_cyc[0] : -1, 7);
        chk("t2_d1", (done_cyc.size() > 1) ? done_cyc[1] : -1, 13);
        chk("t2_d2", (done_cyc.size() > 2) ? done_cyc[2] : -1, 19);
        chk("t2_busy", busy_low, 0);
        chk("t2_noerr", err_seen, 0);
        nxt(); start = 1'b0; tick = 1'b0; stop = 1'b1;
        nxt(); stop = 1'b0; settle();
        chk("t2_stop", busy, 0);

        // start with period 0
        nxt(); start = 1'b1; period_in = 8'd0;
        nxt(); start = 1'b0; settle();
        chk("t3_err", err, 1);
        chk("t3_busy", busy, 0);
        chk("t3_noload", cnt_load, 0);
        nxt(); settle();
        chk("t3_err_pulse", err, 0);

        // stop coincides with expiry tick
        nxt(); start = 1'b1; period_in = 8'd2; periodic = 1'b0; tick = 1'b1;
        nxt(); start = 1'b0;
        nxt();
        nxt(); stop = 1'b1; settle();
        chk("t4_at0", cnt_value, 0);
        chk("t4_nocmd", cnt_enable, 0);
        nxt(); stop = 1'b0; settle();
        chk("t4_nodone", done, 0);
        chk("t4_idle", busy, 0);
        chk("t4_frozen", cnt_value, 0);
        nxt(); settle();
        chk("t4_nodone2", done, 0);

        // disturbed counter value
        nxt(); start = 1'b1; period_in = 8'd10; periodic = 1'b1; tick = 1'b0;
        nxt(); start = 1'b0;
        nxt(); settle();
        chk("t5_first", cnt_value, 9);
        force_en = 1'b1; force_val = 8'hF0; settle();
        chk("t5_nocmd", cnt_enable, 0);
        nxt(); force_en = 1'b0; settle();
        chk("t5_err", err, 1);
        chk("t5_idle", busy, 0);

        // reset mid-RUN overrides a concurrent start
        nxt(); start = 1'b1; period_in = 8'd5; periodic = 1'b1; tick = 1'b1;
        nxt(); start = 1'b0;
        nxt(); res = 1'b1; start = 1'b1;
        nxt(); res = 1'b0; start = 1'b0; settle();
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_cmd", {cnt_enable, cnt_load}, 2'b00);
        chk("t5_rst_lval", cnt_load_val, 0);
        chk("t5_rst_flags", {done, err}, 2'b00);

`ifdef TIMER_CTRL_EXPCNT_EN
        nxt(); start = 1'b1; period_in = 8'd1; periodic = 1'b1; tick = 1'b1;
        nxt(); start = 1'b0;
        for (int c = 0; c < 300; c++) nxt();
        settle();
        chk("t6_done_each", done, 1);
        chk("t6_sat", exp_cnt, 8'hFF);
        stop = 1'b1;
        nxt(); stop = 1'b0;
        nxt(); settle();
        chk("t6_hold", exp_cnt, 8'hFF);
        start = 1'b1; period_in = 8'd3;
        nxt(); start = 1'b0; settle();
        chk("t6_clr", exp_cnt, 0);
`endif

        nxt();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
